ps2_key_event_tracker: RTL and testbench

PS2_KEY_EVENT_TRACKER -- requirements
Module: ps2_key_event_tracker

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_ev_fifo.sv | 49 ++++
 rtl/ps2_key_event_tracker.sv | 178 +++++++++++++++++
 tb/tb_ps2_key_event_tracker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    E0   = 2'd1,
    F0   = 2'd2,
    E0F0 = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } ps2_event_t;

endpackage

// File: rtl/ps2_ev_fifo.sv
// First-word-fall-through event FIFO; a push while full is accepted only
// when a pop frees the head slot in the same cycle.
module ps2_ev_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  ps2_event_t wr_data,
  input  logic       pop,
  output ps2_event_t rd_data,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ps2_key_event_tracker.sv
// Decodes PS/2 set-2 scan bytes into make/break events, counts new presses and
// tracks held keys. Define PS2_TRACKER_REPEAT_EV_EN to also emit typematic repeats.
module ps2_key_event_tracker
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int N_HELD     = 4
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic [7:0]                   ps2_data,
  input  logic                         ps2_ready,
  input  logic                         ps2_overflow,
  output logic                         nextdata_n,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [7:0]                   ev_code,
  output logic                         ev_ext,
  output logic                         ev_break,
  output logic                         ev_repeat,
  output logic [CNT_W-1:0]             press_count,
  output logic [$clog2(N_HELD+1)-1:0]  held_count,
  output logic                         ev_drop,
  output logic                         rx_err
);

  localparam int HC_W = $clog2(N_HELD+1);

  dec_state_t       state_reg, state_next;
  logic             pop_pending_reg;
  logic             consume;
  logic             code_ev, is_ext, is_brk;
  logic [8:0]       cur_key;
  logic [8:0]       key_reg [N_HELD];
  logic [N_HELD-1:0] valid_reg;
  logic [N_HELD-1:0] hit, free_slots, first_free, ins_sel, rem_sel;
  logic             key_held, new_press, is_repeat, is_break;
  logic             ev_push, ev_pop, fifo_empty, fifo_full;
  ps2_event_t       ev_wr, ev_head;
  logic [CNT_W-1:0] press_count_reg;
  logic             ev_drop_reg, rx_err_reg;
  logic [HC_W-1:0]  held_sum;

  // One pop pulse per consumed byte; no consumption while the pulse is out.
  assign consume    = ps2_ready && !pop_pending_reg;
  assign nextdata_n = ~pop_pending_reg;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg       <= IDLE;
      pop_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pop_pending_reg <= consume;
    end
  end

  always_comb begin
    state_next = state_reg;
    code_ev    = 1'b0;
    is_ext     = 1'b0;
    is_brk     = 1'b0;
    if (ps2_overflow) begin
      state_next = IDLE;
    end else if (consume) begin
      unique case (state_reg)
        IDLE: begin
          if (ps2_data == PS2_EXT)      state_next = E0;
          else if (ps2_data == PS2_BRK) state_next = F0;
          else                          code_ev = 1'b1;
        end
        E0: begin
          is_ext = 1'b1;
          if (ps2_data == PS2_BRK) state_next = E0F0;
          else                     code_ev = 1'b1;
        end
        F0: begin
          is_brk  = 1'b1;
          code_ev = 1'b1;
        end
        E0F0: begin
          is_ext  = 1'b1;
          is_brk  = 1'b1;
          code_ev = 1'b1;
        end
      endcase
      if (code_ev) state_next = IDLE;
    end
  end

  assign cur_key    = {is_ext, ps2_data};
  assign key_held   = |hit;
  assign new_press  = code_ev && !is_brk && !key_held;
  assign is_repeat  = code_ev && !is_brk && key_held;
  assign is_break   = code_ev && is_brk;
  assign free_slots = ~valid_reg;
  // Isolate the lowest free slot so a new key lands in exactly one place.
  assign first_free = free_slots & (~free_slots + N_HELD'(1));
  assign ins_sel    = first_free & {N_HELD{new_press}};
  assign rem_sel    = hit & {N_HELD{is_break}};

  generate
    for (genvar gi = 0; gi < N_HELD; gi++) begin : g_slot
      assign hit[gi] = valid_reg[gi] && (key_reg[gi] == cur_key);

      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          valid_reg[gi] <= 1'b0;
          key_reg[gi]   <= '0;
        end else if (ins_sel[gi]) begin
          valid_reg[gi] <= 1'b1;
          key_reg[gi]   <= cur_key;
        end else if (rem_sel[gi]) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    held_sum = '0;
    for (int i = 0; i < N_HELD; i++) begin
      held_sum = held_sum + HC_W'(valid_reg[i]);
    end
  end

`ifdef PS2_TRACKER_REPEAT_EV_EN
  assign ev_push = new_press || is_break || is_repeat;
  assign ev_wr   = '{code: ps2_data, ext: is_ext, brk: is_brk, rpt: is_repeat};
`else
  assign ev_push = new_press || is_break;
  assign ev_wr   = '{code: ps2_data, ext: is_ext, brk: is_brk, rpt: 1'b0};
`endif

  assign ev_pop = ev_valid && ev_ready;

  ps2_ev_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push    (ev_push),
    .wr_data (ev_wr),
    .pop     (ev_pop),
    .rd_data (ev_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      press_count_reg <= '0;
      ev_drop_reg     <= 1'b0;
      rx_err_reg      <= 1'b0;
    end else begin
      if (new_press) press_count_reg <= press_count_reg + CNT_W'(1);
      if (ev_push && fifo_full && !ev_pop) ev_drop_reg <= 1'b1;
      if (ps2_overflow) rx_err_reg <= 1'b1;
    end
  end

  assign ev_valid    = !fifo_empty;
  assign ev_code     = ev_valid ? ev_head.code : 8'h00;
  assign ev_ext      = ev_valid && ev_head.ext;
  assign ev_break    = ev_valid && ev_head.brk;
  assign press_count = press_count_reg;
  assign held_count  = held_sum;
  assign ev_drop     = ev_drop_reg;
  assign rx_err      = rx_err_reg;

`ifdef PS2_TRACKER_REPEAT_EV_EN
  assign ev_repeat = ev_valid && ev_head.rpt;
`else
  logic unused_rpt;
  assign unused_rpt = ev_head.rpt;
  assign ev_repeat  = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_event_tracker.sv
// Randomized bench for ps2_key_event_tracker: key actions are turned into
// scan bytes and checked against a set/queue model of presses and events.
module tb_ps2_key_event_tracker;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = 8;
  localparam int N_HELD = 4;
  localparam int HC_W   = $clog2(N_HELD+1);
`ifdef PS2_TRACKER_REPEAT_EV_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic [7:0]       ps2_data = 8'h00;
  logic             ps2_ready = 1'b0;
  logic             ps2_overflow = 1'b0;
  logic             nextdata_n;
  logic             ev_valid;
  logic             ev_ready = 1'b0;
  logic [7:0]       ev_code;
  logic             ev_ext, ev_break, ev_repeat;
  logic [CNT_W-1:0] press_count;
  logic [HC_W-1:0]  held_count;
  logic             ev_drop, rx_err;

  ps2_key_event_tracker #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .N_HELD(N_HELD)) dut (
    .clk          (clk),
    .clrn         (clrn),
    .ps2_data     (ps2_data),
    .ps2_ready    (ps2_ready),
    .ps2_overflow (ps2_overflow),
    .nextdata_n   (nextdata_n),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_break     (ev_break),
    .ev_repeat    (ev_repeat),
    .press_count  (press_count),
    .held_count   (held_count),
    .ev_drop      (ev_drop),
    .rx_err       (rx_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_events = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: pending bytes, expected events, held-key set, counters.
  logic [7:0]  byte_q [$];
  logic [10:0] exp_q  [$];
  logic [8:0]  held_q [$];
  int          press_cnt = 0;
  bit          exp_drop  = 1'b0;
  bit          cons_en   = 1'b1;

  // Receiver: present the queue head; drop it once the pop pulse is seen.
  always @(negedge clk) begin
    if (nextdata_n === 1'b0 && byte_q.size() > 0) byte_q.delete(0);
    ps2_ready = (byte_q.size() > 0);
    ps2_data  = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
  end

  // Consumer: random back-pressure, each accepted event checked in order.
  always @(negedge clk) begin
    logic [10:0] got, want;
    ev_ready = cons_en && ($urandom_range(0, 9) < 8);
    if (ev_valid && ev_ready) begin
      got  = {ev_code, ev_ext, ev_break, ev_repeat};
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
      n_events++;
      $display("event %0d: code=%02h ext=%0b brk=%0b rpt=%0b (want %03h)",
               n_events, ev_code, ev_ext, ev_break, ev_repeat, want);
      check("ev", {21'b0, got}, {21'b0, want});
    end
  end

  task automatic push_ev(input logic [10:0] e);
    if (!cons_en && exp_q.size() >= DEPTH) exp_drop = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic drain_bytes();
    int g = 0;
    while (byte_q.size() > 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    check("byte_drain", byte_q.size(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_events();
    int g = 0;
    while (exp_q.size() > 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("ev_drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("ev_valid_idle", ev_valid, 0);
  endtask

  task automatic key_action(input bit brk, input logic [7:0] code, input bit ext);
    logic [8:0] key;
    int idx [$];
    key = {ext, code};
    idx = held_q.find_first_index(x) with (x == key);
    if (ext) byte_q.push_back(8'hE0);
    if (brk) byte_q.push_back(8'hF0);
    byte_q.push_back(code);
    if (brk) begin
      if (idx.size() > 0) held_q.delete(idx[0]);
      push_ev({code, ext, 1'b1, 1'b0});
    end else if (idx.size() > 0) begin
      if (REP_EN) push_ev({code, ext, 1'b0, 1'b1});
    end else begin
      press_cnt++;
      if (held_q.size() < N_HELD) held_q.push_back(key);
      push_ev({code, ext, 1'b0, 1'b0});
    end
    drain_bytes();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_press"}, press_count, press_cnt % (1 << CNT_W));
    check({tag, "_held"}, held_count, held_q.size());
  endtask

  task automatic do_reset();
    #2 clrn = 1'b0;
    byte_q.delete();
    exp_q.delete();
    held_q.delete();
    press_cnt = 0;
    exp_drop  = 1'b0;
    #1;
    check("rst_nextdata_n", nextdata_n, 1);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_press", press_count, 0);
    check("rst_held", held_count, 0);
    check("rst_ev_drop", ev_drop, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_ev_fields", {ev_code, ev_ext, ev_break, ev_repeat}, 0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] pool [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h6B, 8'h74, 8'h72};

  initial begin
    do_reset();

    // make / break
    key_action(0, 8'h1C, 0);
    key_action(1, 8'h1C, 0);
    drain_events();
    check_counts("mkbrk");

    // typematic repeats
    do_reset();
    key_action(0, 8'h1C, 0);
    key_action(0, 8'h1C, 0);
    key_action(0, 8'h1C, 0);
    check("rep_held", held_count, 1);
    key_action(1, 8'h1C, 0);
    drain_events();
    check_counts("repeat");

    // extended key
    key_action(0, 8'h75, 1);
    key_action(1, 8'h75, 1);
    drain_events();
    check_counts("ext");

    // randomized key actions
    for (int i = 0; i < 300; i++) begin
      key_action($urandom_range(0, 1), pool[$urandom_range(0, 7)], $urandom_range(0, 1));
      check_counts("rand");
    end
    drain_events();
    check("rand_ev_drop", ev_drop, 0);

    // overflow: lone F0 aborted, held table kept
    byte_q.push_back(8'hF0);
    drain_bytes();
    ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    check("ovf_rx_err", rx_err, 1);
    key_action(0, 8'h4A, 0);
    drain_events();
    check_counts("ovf");

    // full FIFO drops
    do_reset();
    cons_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_action(0, 8'h1C, 0);
      key_action(1, 8'h1C, 0);
    end
    check("drop_flag", ev_drop, exp_drop);
    check("drop_press", press_count, 5);
    check("drop_valid", ev_valid, 1);
    cons_en = 1'b1;
    drain_events();
    check("drop_sticky", ev_drop, 1);

    // reset after lone F0
    do_reset();
    byte_q.push_back(8'hF0);
    drain_bytes();
    do_reset();
    key_action(0, 8'h1C, 0);
    drain_events();
    check("f0rst_press", press_count, 1);

    // counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      key_action(0, 8'h1C, 0);
      key_action(1, 8'h1C, 0);
    end
    drain_events();
    check("wrap_press", press_count, 0);
    check_counts("wrap");

    // held table full
    do_reset();
    for (int i = 0; i < 5; i++) key_action(0, pool[i], 0);
    drain_events();
    check("full_held", held_count, 4);
    check("full_press", press_count, 5);
    key_action(1, pool[4], 0);
    key_action(1, pool[0], 0);
    drain_events();
    check_counts("full_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
